// File: rtl/bwt_pkg.sv
// Shared types for the BWT pipeline: symbol and FSM state types plus
// helpers used by the row-oriented stages.
package bwt_pkg;

    localparam int unsigned SYM_W = 8;

    typedef logic [SYM_W-1:0] sym_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    // Index of the last byte in a row of the given length.
    function automatic int unsigned last_col(input int unsigned column);
        return column - 1;
    endfunction

endpackage

// File: rtl/bwt_row_cmp.sv
// Full-width equality of two rotation rows; shared with the rotation generator.
module bwt_row_cmp
    import bwt_pkg::*;
#(
    parameter int unsigned COLUMN = 3
) (
    input  logic [COLUMN-1:0][SYM_W-1:0] a_i,
    input  logic [COLUMN-1:0][SYM_W-1:0] b_i,
    output logic                         eq_o
);

    always_comb begin
        eq_o = (a_i == b_i);
    end

endmodule

// File: rtl/bwt_last_column.sv
// Final BWT stage: drains sorted rows, emits each row's last byte and reports
// the position of the first row equal to the original string.
module bwt_last_column
    import bwt_pkg::*;
#(
    parameter int unsigned COLUMN = 3,
    parameter int unsigned IDX_W  = (COLUMN > 2) ? $clog2(COLUMN) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [COLUMN-1:0][SYM_W-1:0]  orig_str,
    input  logic                          empty_fifo,
    input  logic [COLUMN-1:0][SYM_W-1:0]  row_in,
    input  logic                          out_rdy,
    output logic                          rd_fifo,
    output logic [SYM_W-1:0]              bwt_byte,
    output logic                          bwt_valid,
    output logic [IDX_W-1:0]              primary_idx,
    output logic                          idx_valid,
    output logic                          no_match,
    output logic                          busy,
    output logic                          done
);

    localparam int unsigned LAST_COL = last_col(COLUMN);

    typedef sym_t [COLUMN-1:0] row_t;

    state_e           state_q, state_d;
    row_t             orig_q, orig_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             found_q, found_d;
    sym_t             byte_q, byte_d;
    logic             bwt_valid_q, bwt_valid_d;
    logic             idx_valid_q, idx_valid_d;
    logic             no_match_q, no_match_d;
    logic             row_eq;

    bwt_row_cmp #(
        .COLUMN (COLUMN)
    ) u_row_cmp (
        .a_i  (row_in),
        .b_i  (orig_q),
        .eq_o (row_eq)
    );

    always_comb begin
        state_d     = state_q;
        orig_d      = orig_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        found_d     = found_q;
        byte_d      = byte_q;
        bwt_valid_d = 1'b0;
        idx_valid_d = idx_valid_q;
        no_match_d  = no_match_q;
        rd_fifo     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RUN;
                    orig_d      = orig_str;
                    cnt_d       = '0;
                    found_d     = 1'b0;
                    idx_valid_d = 1'b0;
                    no_match_d  = 1'b0;
                end
            end
            RUN: begin
                rd_fifo = !empty_fifo && out_rdy;
                if (rd_fifo) begin
                    byte_d      = row_in[LAST_COL];
                    bwt_valid_d = 1'b1;
                    // Periodic strings match several rows; keep the first.
                    if (row_eq && !found_q) begin
                        idx_d   = cnt_q;
                        found_d = 1'b1;
                    end
                    if (cnt_q == IDX_W'(LAST_COL)) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                idx_valid_d = 1'b1;
                no_match_d  = !found_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            orig_q      <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            found_q     <= 1'b0;
            byte_q      <= '0;
            bwt_valid_q <= 1'b0;
            idx_valid_q <= 1'b0;
            no_match_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            orig_q      <= orig_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            found_q     <= found_d;
            byte_q      <= byte_d;
            bwt_valid_q <= bwt_valid_d;
            idx_valid_q <= idx_valid_d;
            no_match_q  <= no_match_d;
        end
    end

    assign bwt_byte    = byte_q;
    assign bwt_valid   = bwt_valid_q;
    assign primary_idx = idx_q;
    assign idx_valid   = idx_valid_q;
    assign no_match    = no_match_q;
    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);

endmodule

// File: tb/tb_bwt_last_column.sv
// Bench for bwt_last_column (COLUMN=3): directed table of blocks, reset and
// idle corner cases, then randomized blocks against a row-level reference.
module tb_bwt_last_column;

    typedef logic [2:0][7:0] row_t;

    typedef struct {
        row_t       orig;
        row_t       r0, r1, r2;
        int         mode;
        bit         poke;
        logic [7:0] b0, b1, b2;
        int         idx;
        bit         nm;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, start, empty_fifo, out_rdy;
    row_t       orig_str, row_in;
    logic       rd_fifo, bwt_valid, idx_valid, no_match, busy, done;
    logic [7:0] bwt_byte;
    logic [1:0] primary_idx;

    bwt_last_column #(
        .COLUMN (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .orig_str    (orig_str),
        .empty_fifo  (empty_fifo),
        .row_in      (row_in),
        .out_rdy     (out_rdy),
        .rd_fifo     (rd_fifo),
        .bwt_byte    (bwt_byte),
        .bwt_valid   (bwt_valid),
        .primary_idx (primary_idx),
        .idx_valid   (idx_valid),
        .no_match    (no_match),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         bad_rd   = 0;
    row_t       fifo[$];
    logic [7:0] got[$];
    row_t       vr[3];
    logic [7:0] eb[3];
    int         ei;
    bit         enm;
    vec_t       vt[5];
    logic       s_valid, s_done, s_busy, s_idxv, s_rd;
    logic [7:0] s_byte;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic row_t mk(input logic [7:0] c0, input logic [7:0] c1,
                                input logic [7:0] c2);
        row_t r;
        r[0] = c0;
        r[1] = c1;
        r[2] = c2;
        return r;
    endfunction

    // Reference: BWT symbol is a row's last character; primary index is the
    // first row equal to the original string.
    task automatic model(input row_t orig);
        ei  = -1;
        enm = 1'b1;
        for (int i = 0; i < 3; i++) begin
            eb[i] = vr[i][2];
            if (enm && vr[i] == orig) begin
                ei  = i;
                enm = 1'b0;
            end
        end
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic step(input bit gap, input bit rdy);
        s_valid    = bwt_valid;
        s_byte     = bwt_byte;
        s_done     = done;
        s_busy     = busy;
        s_idxv     = idx_valid;
        empty_fifo = gap || (fifo.size() == 0);
        row_in     = (fifo.size() > 0) ? fifo[0] : '0;
        out_rdy    = rdy;
        #1;
        s_rd = rd_fifo;
        if (s_rd && (empty_fifo || !out_rdy)) bad_rd++;
        @(posedge clk);
        if (s_rd && fifo.size() > 0) fifo.delete(0);
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_bwt_byte"}, int'(bwt_byte), 0);
        chk({tag, "_bwt_valid"}, int'(bwt_valid), 0);
        chk({tag, "_primary_idx"}, int'(primary_idx), 0);
        chk({tag, "_idx_valid"}, int'(idx_valid), 0);
        chk({tag, "_no_match"}, int'(no_match), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        empty_fifo = 1'b0;
        row_in     = mk(8'h41, 8'h4E, 8'h42);
        out_rdy    = 1'b1;
        #1;
        chk({tag, "_rd_fifo"}, int'(rd_fifo), 0);
    endtask

    task automatic run_block(input string tag, input row_t orig, input int mode, input bit poke);
        int  last_rd = -1, done_cnt = 0, done_at = -1, idxv_at = -1;
        int  pops = 0, lat_err = 0, busy_err = 0, idle_pop = 0;
        bit  prev_rd;
        bit  gap, rdy;
        got.delete();
        fifo.delete();
        for (int i = 0; i < 3; i++) fifo.push_back(vr[i]);
        fifo.push_back(mk(8'hFF, 8'hEE, 8'hDD));  // must survive the block
        repeat (2) begin
            step(1'b0, 1'b1);
            if (s_rd) idle_pop++;
        end
        start    = 1'b1;
        orig_str = orig;
        step(1'b0, 1'b1);
        if (s_rd) idle_pop++;
        start    = 1'b0;
        orig_str = ~orig;
        prev_rd  = 1'b0;
        for (int k = 1; k < 60 && idxv_at < 0; k++) begin
            gap = 1'b0;
            rdy = 1'b1;
            if (mode == 1) rdy = !(k >= 2 && k <= 4);
            if (mode == 2) begin
                gap = ($urandom_range(0, 2) == 0);
                rdy = ($urandom_range(0, 3) != 0);
            end
            if (poke && k == 2) begin
                start    = 1'b1;
                orig_str = vr[2];
            end
            step(gap, rdy);
            start = 1'b0;
            if (s_valid) got.push_back(s_byte);
            if (s_valid != prev_rd) lat_err++;
            if (s_done) begin
                done_cnt++;
                done_at = k;
            end
            if (s_idxv && idxv_at < 0) idxv_at = k;
            if (s_busy != (pops < 3)) busy_err++;
            if (s_rd) begin
                pops++;
                last_rd = k;
            end
            prev_rd = s_rd;
        end
        chk({tag, "_timeout"}, int'(idxv_at >= 0), 1);
        chk({tag, "_idle_pops"}, idle_pop, 0);
        chk({tag, "_pops"}, pops, 3);
        chk({tag, "_fifo_left"}, fifo.size(), 1);
        chk({tag, "_valid_latency"}, lat_err, 0);
        chk({tag, "_busy"}, busy_err, 0);
        chk({tag, "_done_count"}, done_cnt, 1);
        chk({tag, "_done_at"}, done_at, last_rd + 1);
        chk({tag, "_idx_valid_at"}, idxv_at, last_rd + 2);
    endtask

    task automatic compare_block(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                                 input logic [7:0] b2, input int idx, input bit nm);
        logic [7:0] exp_b[3];
        exp_b[0] = b0;
        exp_b[1] = b1;
        exp_b[2] = b2;
        chk({tag, "_byte_count"}, got.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < got.size()) chk($sformatf("%s_byte%0d", tag, i), int'(got[i]), int'(exp_b[i]));
        end
        chk({tag, "_idx_valid"}, int'(idx_valid), 1);
        chk({tag, "_no_match"}, int'(no_match), int'(nm));
        if (!nm) chk({tag, "_primary_idx"}, int'(primary_idx), idx);
    endtask

    initial begin
        row_t anb, ban, nba, aaa, cat, orig;
        anb = mk(8'h41, 8'h4E, 8'h42);
        ban = mk(8'h42, 8'h41, 8'h4E);
        nba = mk(8'h4E, 8'h42, 8'h41);
        aaa = mk(8'h41, 8'h41, 8'h41);
        cat = mk(8'h43, 8'h41, 8'h54);

        vt[0] = '{ban, anb, ban, nba, 0, 1'b0, 8'h42, 8'h4E, 8'h41, 1, 1'b0};
        vt[1] = '{ban, anb, ban, nba, 1, 1'b0, 8'h42, 8'h4E, 8'h41, 1, 1'b0};
        vt[2] = '{aaa, aaa, aaa, aaa, 0, 1'b0, 8'h41, 8'h41, 8'h41, 0, 1'b0};
        vt[3] = '{cat, anb, ban, nba, 0, 1'b0, 8'h42, 8'h4E, 8'h41, 0, 1'b1};
        vt[4] = '{ban, anb, ban, nba, 2, 1'b1, 8'h42, 8'h4E, 8'h41, 1, 1'b0};

        rst        = 1'b1;
        start      = 1'b0;
        orig_str   = '0;
        empty_fifo = 1'b1;
        row_in     = '0;
        out_rdy    = 1'b0;
        @(negedge clk);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        rst = 1'b0;
        check_reset_vals("reset");

        for (int v = 0; v < 5; v++) begin
            vr[0] = vt[v].r0;
            vr[1] = vt[v].r1;
            vr[2] = vt[v].r2;
            run_block($sformatf("vec%0d", v), vt[v].orig, vt[v].mode, vt[v].poke);
            compare_block($sformatf("vec%0d", v), vt[v].b0, vt[v].b1, vt[v].b2,
                          vt[v].idx, vt[v].nm);
        end

        // Abort after two reads: byte and index registers are non-zero then.
        fifo.delete();
        fifo.push_back(anb);
        fifo.push_back(ban);
        fifo.push_back(nba);
        start    = 1'b1;
        orig_str = ban;
        step(1'b0, 1'b1);
        start = 1'b0;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        rst = 1'b1;
        step(1'b0, 1'b1);
        rst = 1'b0;
        check_reset_vals("midrst");
        vr[0] = anb;
        vr[1] = ban;
        vr[2] = nba;
        run_block("after_rst", ban, 0, 1'b0);
        compare_block("after_rst", 8'h42, 8'h4E, 8'h41, 1, 1'b0);

        for (int n = 0; n < 24; n++) begin
            int   j;
            row_t t;
            for (int c = 0; c < 3; c++) orig[c] = 8'h41 + 8'($urandom_range(0, 1));
            for (int k = 0; k < 3; k++)
                for (int c = 0; c < 3; c++) vr[k][c] = orig[(c + k) % 3];
            for (int i = 2; i > 0; i--) begin
                j     = $urandom_range(0, i);
                t     = vr[i];
                vr[i] = vr[j];
                vr[j] = t;
            end
            if ($urandom_range(0, 3) == 0) begin
                j = $urandom_range(0, 2);
                for (int c = 0; c < 3; c++) vr[j][c] = 8'h41 + 8'($urandom_range(0, 2));
            end
            model(orig);
            run_block($sformatf("rnd%0d", n), orig, 2, 1'($urandom_range(0, 1)));
            compare_block($sformatf("rnd%0d", n), eb[0], eb[1], eb[2], ei, enm);
        end

        chk("rd_fifo_when_blocked", bad_rd, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
